// File: rtl/ifetch_pkg.sv
// Shared types and width helpers for the instruction-fetch stage.
//   state_t : fetch controller states (RUN = fetching, REQ = waiting on refill)
//   INS_W   : instruction width
//   off_w / idx_w / tag_w : address-field widths derived from the parameters
package ifetch_pkg;

  typedef enum logic {
    RUN = 1'b0,
    REQ = 1'b1
  } state_t;

  localparam int INS_W = 32;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
    return addr_w - idx_w(num_lines) - off_w(line_words) - 2;
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache storage: tag, valid and data arrays.
//   clk, rstn     : clock, async active-low reset (clears all valid bits)
//   rd_addr       : word address (byte offset dropped) for the combinational lookup
//   rd_hit        : line valid and tag matches
//   rd_ins        : selected word of the indexed line
//   wr_en         : write a full line this cycle
//   wr_line_addr  : line address (word/byte offset dropped) of the line to write
//   wr_line       : line data, word 0 in the low 32 bits
module icache_dm
  import ifetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [ADDR_W-1:2]           rd_addr,
  output logic                        rd_hit,
  output logic [INS_W-1:0]            rd_ins,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:off_w(LINE_WORDS)+2] wr_line_addr,
  input  logic [INS_W*LINE_WORDS-1:0] wr_line
);

  localparam int OFF_W   = off_w(LINE_WORDS);
  localparam int IDX_W   = idx_w(NUM_LINES);
  localparam int TAG_W   = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
  localparam int IDX_LSB = OFF_W + 2;
  localparam int TAG_LSB = OFF_W + IDX_W + 2;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [INS_W-1:0]     data [NUM_LINES][LINE_WORDS];

  logic [IDX_W-1:0] rd_idx;
  logic [OFF_W-1:0] rd_word;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;

  assign rd_word = rd_addr[OFF_W+1:2];
  assign rd_idx  = rd_addr[IDX_LSB +: IDX_W];
  assign rd_tag  = rd_addr[ADDR_W-1:TAG_LSB];
  assign wr_idx  = wr_line_addr[IDX_LSB +: IDX_W];
  assign wr_tag  = wr_line_addr[ADDR_W-1:TAG_LSB];

  assign rd_hit = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_ins = data[rd_idx][rd_word];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      for (int k = 0; k < LINE_WORDS; k++) begin
        data[wr_idx][k] <= wr_line[k*INS_W +: INS_W];
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC, direct-mapped I-cache and miss refill FSM.
//   clk, rstn            : clock, async active-low reset
//   i_stall              : downstream busy, hold PC on a hit
//   i_redirect, i_target : branch redirect (highest priority)
//   o_mem_req, o_mem_addr: line refill request and line-aligned address
//   i_mem_ack, i_mem_line: one-cycle refill response and line data
//   o_valid, o_ins       : fetched instruction and its valid flag
//   o_pc, o_pc_plus4     : current PC and PC + 4
//   o_hit                : lookup hit while fetching
//   o_miss_count         : saturating miss counter
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              LINE_WORDS = 4,
  parameter int              NUM_LINES  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_stall,
  input  logic                        i_redirect,
  input  logic [ADDR_W-1:0]           i_target,
  output logic                        o_mem_req,
  output logic [ADDR_W-1:0]           o_mem_addr,
  input  logic                        i_mem_ack,
  input  logic [INS_W*LINE_WORDS-1:0] i_mem_line,
  output logic                        o_valid,
  output logic [INS_W-1:0]            o_ins,
  output logic [ADDR_W-1:0]           o_pc,
  output logic [ADDR_W-1:0]           o_pc_plus4,
  output logic                        o_hit,
  output logic [15:0]                 o_miss_count
);

  localparam int LINE_LSB = off_w(LINE_WORDS) + 2;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] line_addr;
  logic [15:0]       miss_count;
  logic              mem_req;
  logic              lookup_hit;
  logic [INS_W-1:0]  lookup_ins;
  logic [ADDR_W-1:0] target_aligned;
  logic              fill;
  logic              unused_target_lsbs;

  assign target_aligned     = {i_target[ADDR_W-1:2], 2'b00};
  assign unused_target_lsbs = ^i_target[1:0];
  assign fill               = (state == REQ) && i_mem_ack;

  icache_dm #(
    .ADDR_W    (ADDR_W),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_cache (
    .clk         (clk),
    .rstn        (rstn),
    .rd_addr     (pc[ADDR_W-1:2]),
    .rd_hit      (lookup_hit),
    .rd_ins      (lookup_ins),
    .wr_en       (fill),
    .wr_line_addr(line_addr[ADDR_W-1:LINE_LSB]),
    .wr_line     (i_mem_line)
  );

  // line_addr doubles as o_mem_addr, so it is zeroed whenever a refill completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RUN;
      pc         <= RESET_PC;
      line_addr  <= '0;
      miss_count <= '0;
      mem_req    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (i_redirect) begin
            pc <= target_aligned;
          end else if (lookup_hit) begin
            if (!i_stall) pc <= pc + ADDR_W'(4);
          end else begin
            line_addr <= {pc[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            mem_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // Redirect and ack are independent here; both may land together.
          if (i_redirect) pc <= target_aligned;
          if (i_mem_ack) begin
            mem_req   <= 1'b0;
            line_addr <= '0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign o_mem_req    = mem_req;
  assign o_mem_addr   = line_addr;
  assign o_hit        = (state == RUN) && lookup_hit;
  assign o_valid      = o_hit;
  assign o_ins        = lookup_ins;
  assign o_pc         = pc;
  assign o_pc_plus4   = pc + ADDR_W'(4);
  assign o_miss_count = miss_count;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Parametrised instruction-fetch stage with its own PC, direct-mapped instruction cache and miss-refill state machine.
- Outputs one instruction per cycle on a hit. On a miss it stalls and refills a full line over a req/ack memory handshake.
- Supports a stall from downstream and a branch redirect from MEM.
- Sits between the memory arbiter and the IF/ID pipeline register.

Parameters:
ADDR_W, 32, PC / address width in bits (>= 16)
LINE_WORDS, 4, 32-bit words per cache line (power of 2, >= 2)
NUM_LINES, 16, cache lines (power of 2, >= 2)
RESET_PC, 0, PC value after reset (word aligned)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
i_stall  in  1  downstream cannot accept instruction; hold PC
i_redirect  in  1  branch taken; load i_target into PC
i_target  in  ADDR_W  branch target address
o_mem_req  out  1  line refill request
o_mem_addr  out  ADDR_W  line-aligned refill address
i_mem_ack  in  1  one-cycle pulse; i_mem_line valid this cycle
i_mem_line  in  32*LINE_WORDS  refill data, word 0 in bits [31:0]
o_valid  out  1  o_ins/o_pc valid this cycle
o_ins  out  32  fetched instruction
o_pc  out  ADDR_W  current PC
o_pc_plus4  out  ADDR_W  o_pc + 4, modulo 2^ADDR_W
o_hit  out  1  lookup hit in RUN state
o_miss_count  out  16  saturating count of misses

Behaviour:
- Address split: offset = pc[1:0], ignored and forced to 0 on load. Word = next log2(LINE_WORDS) bits. Index = next log2(NUM_LINES) bits. Tag = remaining upper bits.
- Reset (async, rstn=0):
  - PC = RESET_PC.
  - All line valid bits = 0.
  - State = RUN.
  - o_mem_req = 0, o_miss_count = 0.
  - Reset takes effect mid-refill as well: the request drops immediately, and no line write happens even if i_mem_ack is high.
- Lookup is combinational from PC (zero-latency): o_hit = valid[idx] && tag[idx] == pc tag.
- State RUN:
  - o_valid = o_hit; o_ins = line[idx].word[w]; o_mem_req = 0.
  - i_redirect: PC <= {i_target[ADDR_W-1:2], 2'b00}. Redirect has priority over every other event.
  - Else hit && !i_stall: PC <= PC + 4, wrapping to 0 past all-ones.
  - Else hit && i_stall: PC holds.
  - Else miss: latch line address {pc[ADDR_W-1:lineoff], 0}; o_miss_count += 1, saturating at 16'hFFFF; go to REQ.
  - PC holds on a miss (no redirect).
- State REQ:
  - o_mem_req = 1 and o_mem_addr holds the latched line address, both stable until ack.
  - o_valid = 0, o_hit = 0.
  - On i_mem_ack: write i_mem_line, tag and valid=1 into the latched index; go to RUN.
  - The next cycle re-looks-up and hits. Total miss penalty = ack latency + 1 cycle.
- Redirect during REQ:
  - PC takes the target immediately.
  - The outstanding request is not withdrawn; the refill completes and is written.
  - After returning to RUN, lookup uses the new PC; it may miss again.
- Redirect and ack in the same cycle: both take effect.
- i_stall is ignored in REQ (o_valid is already 0).
- o_mem_addr in RUN = 0.
- There is no cache invalidate input; contents persist until reset.
- Conflicting lines evict unconditionally; no replacement state is needed.

Decomposition:
- Package ifetch_pkg holds:
  - State enum {RUN, REQ}.
  - Localparam helpers: OFF_W = $clog2(LINE_WORDS), IDX_W = $clog2(NUM_LINES), TAG_W = ADDR_W - IDX_W - OFF_W - 2.
  - Instruction width constant 32.
- Sub-module icache_dm holds the tag/valid/data arrays.
  - Read side: async read by index, with word mux and hit compare.
  - Write side: a single write port with a line clear on rstn.
  - It is parametrised by LINE_WORDS, NUM_LINES, ADDR_W.
- The FSM, PC and counter live in ifetch_unit.

Test Plan:
- Reset, RESET_PC=0x100, then release:
  - Cycle 0 misses: o_valid=0, o_miss_count=1.
  - Next cycle: o_mem_req=1, o_mem_addr=0x100.
  - Ack after 3 cycles with line {0xD,0xC,0xB,0xA}: the following cycle gives o_valid=1, o_ins=0xA, o_pc=0x100, o_pc_plus4=0x104.
- Sequential hits after the above fill: four consecutive cycles give o_ins 0xA, 0xB, 0xC, 0xD at PC 0x100..0x10C. PC=0x110 then misses, o_miss_count=2.
- i_stall=1 for 3 cycles while hitting at 0x104: o_pc stays 0x104 and o_valid stays 1 throughout. On release, the next cycle gives PC=0x108.
- Redirect:
  - i_redirect with i_target=0x207 during REQ for 0x110: o_pc=0x204 immediately and o_mem_addr stays 0x110 until ack.
  - After ack the line at 0x110 hits on a later fetch of 0x110, and 0x204 triggers a new miss.
- Conflict eviction (default params, line stride 0x100): fill 0x100 then fetch 0x200, which misses. Refetch 0x100 also misses; o_miss_count increments each time.
- Assert rstn low while o_mem_req=1 and i_mem_ack=1:
  - o_mem_req=0 immediately and o_miss_count=0.
  - After release, PC=RESET_PC and the next fetch misses (all lines invalid).
